// File: rtl/tick_scheduler.sv
// Shared-timebase tick scheduler: one free-running prescaler feeds a base tick
// that is time-shared by NCH independently armed periodic/one-shot channels.
module tick_scheduler #(
  parameter int unsigned PRESCALE = 10000000,
  parameter int unsigned NCH      = 4,
  parameter int unsigned CW       = 16,
  parameter int unsigned AW       = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_ch,
  input  logic [CW-1:0]  cfg_period,
  input  logic           cfg_oneshot,
  input  logic [NCH-1:0] ch_stop,
  output logic           base_tick,
  output logic [NCH-1:0] tick_o,
  output logic [NCH-1:0] clk_o,
  output logic [NCH-1:0] active,
  output logic           cfg_err
);

  localparam int unsigned PW = $clog2(PRESCALE);

  typedef enum logic {StIdle, StRun} state_e;

  logic [PW-1:0]  pre_q, pre_d;
  logic           pre_wrap;
  logic           base_q, base_d;
  logic           err_q, err_d;
  logic [NCH-1:0] ch_sel;
  logic           arm_ok;

  state_e         state_q  [NCH];
  state_e         state_d  [NCH];
  logic [CW-1:0]  period_q [NCH];
  logic [CW-1:0]  period_d [NCH];
  logic [CW-1:0]  cnt_q    [NCH];
  logic [CW-1:0]  cnt_d    [NCH];
  logic [NCH-1:0] oneshot_q, oneshot_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] clko_q, clko_d;

  // Prescaler: free-running, never gated by channel activity.
  always_comb begin
    pre_wrap = (pre_q == PW'(PRESCALE - 1));
    pre_d    = pre_wrap ? '0 : pre_q + PW'(1);
    base_d   = pre_wrap;
  end

  // Decode the channel select; an out-of-range index selects nothing.
  always_comb begin
    ch_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_sel[k] = (cfg_ch == AW'(k));
    end
  end

  assign arm_ok = cfg_we && (cfg_period != '0) && (|ch_sel);
  assign err_d  = cfg_we && ((cfg_period == '0) || !(|ch_sel));

  // Per-channel next state. Priority: stop, then arm, then expiry.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    oneshot_d = oneshot_q;
    clko_d    = clko_q;
    tick_d    = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_stop[k]) begin
        state_d[k] = StIdle;
        cnt_d[k]   = '0;
      end else if (arm_ok && ch_sel[k]) begin
        state_d[k]   = StRun;
        period_d[k]  = cfg_period;
        oneshot_d[k] = cfg_oneshot;
        cnt_d[k]     = '0;
        clko_d[k]    = 1'b0;
      end else if (state_q[k] == StRun && base_q) begin
        if (cnt_q[k] == period_q[k] - CW'(1)) begin
          tick_d[k] = 1'b1;
          clko_d[k] = ~clko_q[k];
          cnt_d[k]  = '0;
          if (oneshot_q[k]) begin
            state_d[k] = StIdle;
          end
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      base_q    <= 1'b0;
      err_q     <= 1'b0;
      tick_q    <= '0;
      clko_q    <= '0;
      oneshot_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        state_q[k]  <= StIdle;
        period_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
    end else begin
      pre_q     <= pre_d;
      base_q    <= base_d;
      err_q     <= err_d;
      tick_q    <= tick_d;
      clko_q    <= clko_d;
      oneshot_q <= oneshot_d;
      for (int k = 0; k < NCH; k++) begin
        state_q[k]  <= state_d[k];
        period_q[k] <= period_d[k];
        cnt_q[k]    <= cnt_d[k];
      end
    end
  end

  always_comb begin
    active = '0;
    for (int k = 0; k < NCH; k++) begin
      active[k] = (state_q[k] == StRun);
    end
  end

  assign base_tick = base_q;
  assign tick_o    = tick_q;
  assign clk_o     = clko_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios plus random traffic,
// all compared against a countdown-based behavioural model.
module tb_tick_scheduler;

  localparam int P   = 4;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int AW  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [AW-1:0]  cfg_ch = '0;
  logic [CW-1:0]  cfg_period = '0;
  logic           cfg_oneshot = 1'b0;
  logic [NCH-1:0] ch_stop = '0;
  logic           base_tick;
  logic [NCH-1:0] tick_o;
  logic [NCH-1:0] clk_o;
  logic [NCH-1:0] active;
  logic           cfg_err;

  tick_scheduler #(
    .PRESCALE (P),
    .NCH      (NCH),
    .CW       (CW),
    .AW       (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_oneshot (cfg_oneshot),
    .ch_stop     (ch_stop),
    .base_tick   (base_tick),
    .tick_o      (tick_o),
    .clk_o       (clk_o),
    .active      (active),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: cycles since release, and per channel the base ticks still to wait.
  int           m_cyc;
  bit           m_base, m_err;
  bit [NCH-1:0] m_run, m_tick, m_clk, m_one;
  int           m_rem [NCH];
  int           m_per [NCH];

  function automatic logic [13:0] obs();
    return {base_tick, cfg_err, active, clk_o, tick_o};
  endfunction

  function automatic logic [13:0] expv();
    return {m_base, m_err, m_run, m_clk, m_tick};
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_base = 0; m_err = 0;
    m_run = '0; m_tick = '0; m_clk = '0; m_one = '0;
    for (int k = 0; k < NCH; k++) begin
      m_rem[k] = 0;
      m_per[k] = 0;
    end
  endtask

  // Advance one clock: predict from the inputs present before the edge.
  task automatic step();
    bit           nb, ne;
    bit [NCH-1:0] nr, nt, nc, no;
    int           nrem [NCH];
    int           nper [NCH];
    nr = m_run; nc = m_clk; no = m_one; nt = '0;
    nrem = m_rem; nper = m_per;
    ne = cfg_we && (cfg_period == 0);
    nb = ((m_cyc + 1) % P) == 0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_stop[k]) begin
        nr[k] = 0;
      end else if (cfg_we && cfg_period != 0 && int'(cfg_ch) == k) begin
        nr[k] = 1; nper[k] = int'(cfg_period); nrem[k] = int'(cfg_period);
        no[k] = cfg_oneshot; nc[k] = 0;
      end else if (m_run[k] && m_base) begin
        nrem[k]--;
        if (nrem[k] == 0) begin
          nt[k] = 1;
          nc[k] = ~nc[k];
          if (no[k]) nr[k] = 0;
          else nrem[k] = nper[k];
        end
      end
    end
    @(posedge clk);
    #1;
    m_cyc++; m_base = nb; m_err = ne;
    m_run = nr; m_tick = nt; m_clk = nc; m_one = no;
    m_rem = nrem; m_per = nper;
  endtask

  task automatic arm(input int ch, input int per, input bit one);
    cfg_we = 1; cfg_ch = AW'(ch); cfg_period = CW'(per); cfg_oneshot = one;
    step();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    if (obs() !== 14'h0) begin
      bad++; $display("FAIL reset_hold obs=%h exp=%h", obs(), 14'h0);
    end
    total++;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    repeat (13) begin
      step();
      if (obs() !== expv()) begin
        bad++; $display("FAIL reset_prescale cyc=%0d obs=%h exp=%h", m_cyc, obs(), expv());
      end
      total++;
    end
  endtask

  task automatic test_periodic();
    int last = -1, nbt, nticks = 0;
    arm(0, 3, 0);
    nbt = base_tick;
    repeat (60) begin
      step();
      if (obs() !== expv()) begin
        bad++; $display("FAIL periodic cyc=%0d obs=%h exp=%h", m_cyc, obs(), expv());
      end
      total++;
      if (tick_o[0]) begin
        if (last < 0) begin
          if (nbt !== 3) begin
            bad++; $display("FAIL periodic_first base_ticks=%0d exp=3", nbt);
          end
        end else if (m_cyc - last !== 12) begin
          bad++; $display("FAIL periodic_spacing got=%0d exp=12", m_cyc - last);
        end
        total++;
        last = m_cyc;
        nticks++;
      end else if (last < 0) begin
        nbt += base_tick;
      end
    end
    if (nticks < 4) begin
      bad++; $display("FAIL periodic_count got=%0d exp>=4", nticks);
    end
    total++;
  endtask

  task automatic test_oneshot();
    int n = 0;
    arm(1, 2, 1);
    repeat (110) begin
      step();
      if (obs() !== expv()) begin
        bad++; $display("FAIL oneshot cyc=%0d obs=%h exp=%h", m_cyc, obs(), expv());
      end
      total++;
      if (tick_o[1]) begin
        n++;
        if (active[1] !== 1'b0) begin
          bad++; $display("FAIL oneshot_active got=%b exp=0", active[1]);
        end
        total++;
      end
    end
    if (n !== 1) begin
      bad++; $display("FAIL oneshot_count got=%0d exp=1", n);
    end
    total++;
  endtask

  task automatic test_cfg_err();
    int last = -1, nsp = 0;
    arm(2, 5, 0);
    repeat (25) step();
    cfg_we = 1; cfg_ch = 2; cfg_period = 0;
    step();
    cfg_we = 0;
    if (cfg_err !== 1'b1 || active[2] !== 1'b1) begin
      bad++; $display("FAIL cfg_err_pulse err=%b act=%b exp=1,1", cfg_err, active[2]);
    end
    total++;
    step();
    if (cfg_err !== 1'b0) begin
      bad++; $display("FAIL cfg_err_single got=%b exp=0", cfg_err);
    end
    total++;
    repeat (60) begin
      step();
      if (obs() !== expv()) begin
        bad++; $display("FAIL cfg_err_run cyc=%0d obs=%h exp=%h", m_cyc, obs(), expv());
      end
      total++;
      if (tick_o[2]) begin
        if (last >= 0) begin
          if (m_cyc - last !== 20) begin
            bad++; $display("FAIL cfg_err_spacing got=%0d exp=20", m_cyc - last);
          end
          total++;
          nsp++;
        end
        last = m_cyc;
      end
    end
    if (nsp < 1) begin
      bad++; $display("FAIL cfg_err_ticks got=%0d exp>=1", nsp);
    end
    total++;
  endtask

  task automatic test_stop();
    int  nbt = 0;
    bit  held, seen = 0;
    arm(0, 4, 0);
    for (int i = 0; i < 20 && nbt < 2; i++) begin
      step();
      nbt += base_tick;
    end
    held = clk_o[0];
    ch_stop = 4'b0001;
    step();
    ch_stop = '0;
    if (active[0] !== 1'b0 || clk_o[0] !== held) begin
      bad++; $display("FAIL stop act=%b clk=%b exp=0,%b", active[0], clk_o[0], held);
    end
    total++;
    arm(0, 4, 0);
    nbt = base_tick;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (obs() !== expv()) begin
        bad++; $display("FAIL rearm cyc=%0d obs=%h exp=%h", m_cyc, obs(), expv());
      end
      total++;
      if (tick_o[0]) begin
        seen = 1;
        if (nbt !== 4) begin
          bad++; $display("FAIL rearm_delay base_ticks=%0d exp=4", nbt);
        end
        total++;
      end else begin
        nbt += base_tick;
      end
    end
    if (!seen) begin
      bad++; $display("FAIL rearm_timeout tick=0 exp=1");
      total++;
    end
    ch_stop = 4'b0001;
    cfg_we = 1; cfg_ch = 0; cfg_period = 4; cfg_oneshot = 0;
    step();
    cfg_we = 0; ch_stop = '0;
    if (active[0] !== 1'b0 || cfg_err !== 1'b0) begin
      bad++; $display("FAIL stop_arm act=%b err=%b exp=0,0", active[0], cfg_err);
    end
    total++;
  endtask

  task automatic test_all_reset();
    int nall = 0, nany = 0;
    for (int k = 0; k < NCH; k++) arm(k, 1, 0);
    repeat (12) begin
      step();
      if (obs() !== expv()) begin
        bad++; $display("FAIL all_ch cyc=%0d obs=%h exp=%h", m_cyc, obs(), expv());
      end
      total++;
      if (tick_o === 4'b1111) nall++;
    end
    if (nall < 2) begin
      bad++; $display("FAIL all_ch_count got=%0d exp>=2", nall);
    end
    total++;
    #2 rst_n = 0;
    #1;
    if (obs() !== 14'h0) begin
      bad++; $display("FAIL midrun_reset obs=%h exp=%h", obs(), 14'h0);
    end
    total++;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    repeat (30) begin
      step();
      if (obs() !== expv()) begin
        bad++; $display("FAIL post_reset cyc=%0d obs=%h exp=%h", m_cyc, obs(), expv());
      end
      total++;
      if (tick_o !== '0 || active !== '0) nany++;
    end
    if (nany !== 0) begin
      bad++; $display("FAIL post_reset_idle got=%0d exp=0", nany);
    end
    total++;
  endtask

  task automatic test_random();
    repeat (400) begin
      cfg_we      = ($urandom % 5) == 0;
      cfg_ch      = AW'($urandom);
      cfg_period  = CW'($urandom % 6);
      cfg_oneshot = 1'($urandom);
      ch_stop     = (($urandom % 12) == 0) ? NCH'($urandom) : '0;
      step();
      if (obs() !== expv()) begin
        bad++; $display("FAIL random cyc=%0d obs=%h exp=%h", m_cyc, obs(), expv());
      end
      total++;
    end
    cfg_we = 0; ch_stop = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_periodic();
    test_oneshot();
    test_cfg_err();
    test_stop();
    test_all_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Shared timebase controller: one free-running prescaler generates a base tick, which is time-shared among NCH independently programmed timer channels.
- Each channel can run periodic or one-shot. It emits a one-cycle tick pulse and a divided toggle clock.
- Sits between the system clock and slow consumers (LED blink, debounce sampling, display refresh), replacing one dedicated divider per consumer.

Parameters:
- PRESCALE, 10000000, clk cycles per base tick (>=2).
- NCH, 4, number of timer channels (2..8).
- CW, 16, channel period/counter width in base ticks.
- AW, 2, channel select width; must equal clog2(NCH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  single-cycle write strobe; arms the selected channel
- cfg_ch  in  AW  channel index for cfg_we
- cfg_period  in  CW  period in base ticks; 0 is illegal
- cfg_oneshot  in  1  1 = one-shot, 0 = periodic
- ch_stop  in  NCH  per-channel stop request, level-sampled each clk
- base_tick  out  1  one-cycle pulse every PRESCALE clk
- tick_o  out  NCH  per-channel one-cycle expiry pulse
- clk_o  out  NCH  per-channel divided clock, toggles on each expiry
- active  out  NCH  channel in RUN state
- cfg_err  out  1  one-cycle pulse on an illegal write

Behaviour:
- Reset: asynchronous, active-low; clock clk. All outputs 0, all channels IDLE, all counters 0, prescaler 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps; free-running from reset release, never stopped by channels.
  - base_tick is registered and is high in the cycle after the prescaler count reaches PRESCALE-1. It is high exactly 1 of every PRESCALE cycles; the first pulse comes PRESCALE cycles after reset release.
- Channel FSM, per channel: states IDLE and RUN; registers period, oneshot, cnt.
- Arm (cfg_we=1, cfg_period!=0, cfg_ch=k):
  - Next cycle: channel k is RUN, period/oneshot latched, cnt=0, clk_o[k]=0, active[k]=1.
  - Legal in either state; re-arm while RUN restarts the count.
- Illegal write (cfg_period==0): no channel state change; cfg_err=1 for one cycle, registered.
- cfg_ch >= NCH: write ignored, cfg_err=1.
- RUN counting: at each clk edge where base_tick=1:
  - If cnt==period-1: tick_o[k]=1 next cycle, clk_o[k] toggles. Periodic: cnt<=0, stay RUN. One-shot: go IDLE, active[k]=0 in the same cycle tick_o[k] rises.
  - Otherwise cnt<=cnt+1.
- Tick timing: first tick_o arrives on the period-th base_tick pulse sampled after the arm edge. Periodic tick spacing is exactly period*PRESCALE clk.
- tick_o: one cycle only, never asserted in IDLE.
- Stop: ch_stop[k]=1 while RUN gives IDLE next cycle, active[k]=0, cnt=0, clk_o[k] holds its value. No effect in IDLE.
- Simultaneous events on the same channel, same cycle:
  - stop + arm: stop wins; channel ends IDLE, no cfg_err.
  - arm + expiry: arm wins, no tick, cnt=0.
  - stop + expiry: stop wins, no tick.
- Channels are fully independent; any number may tick in the same cycle.
- cnt width is CW. period=1 ticks on every base tick. period=2^CW-1 is the maximum; no overflow is possible since cnt < period.
- Reset asserted mid-operation returns everything immediately to reset values. Channels stay IDLE after release until re-armed.

Test Plan:
- PRESCALE=4, CW=8. Release reset -> base_tick high at cycles 4, 8, 12…, exactly one cycle each; all other outputs stay 0.
- Arm ch0 periodic, period=3 -> tick_o[0] pulses every 12 clk, first on the 3rd base_tick after the write; clk_o[0] is a 24-clk-period square wave; active[0] stays 1.
- Arm ch1 one-shot, period=2 -> exactly one tick_o[1] on the 2nd base_tick; active[1] falls in the same cycle; no further ticks over 100 clk.
- Write period=0 to ch2 while ch2 is RUN with period=5 -> cfg_err one cycle; ch2 continues ticking every 20 clk, unperturbed.
- ch0 period=4 running: pulse ch_stop[0] after 2 base ticks -> active[0]=0, clk_o[0] held. Re-arm period=4 -> next tick exactly 4 base ticks later. Also assert stop+arm in the same cycle -> channel IDLE.
- All four channels period=1 periodic -> tick_o=4'b1111 on every base tick. Drop rst_n mid-run -> outputs 0 immediately; no ticks after release until re-armed.
